// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Holds the program counter that addresses a combinational program ROM.
// Latches each fetched word into the instruction register (IR) and hands it
// downstream as decoded fields over a valid/ready handshake.
// Bit 0 of every ROM word marks it as a real instruction, so an all-zero
// (unprogrammed) location reads as invalid.
// An invalid word either halts the stage or is skipped, depending on
// HALT_ON_INVALID.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter bit          HALT_ON_INVALID = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] rom_addr,
    input  logic [26:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [2:0]  opcode,
    output logic        op_flag,
    output logic [1:0]  fld_a,
    output logic [1:0]  fld_b,
    output logic [1:0]  fld_dst,
    output logic [15:0] imm,
    output logic [15:0] instr_pc,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [26:0] ir_q, ir_d;
    logic [15:0] ipc_q, ipc_d;

    logic [15:0] pc_inc;
    logic        word_ok;

    // Wraps modulo 2^16 by plain 16-bit overflow; a wrap is not an error.
    assign pc_inc  = pc_q + 16'd1;
    assign word_ok = rom_data[0];

    // State, PC, IR and fetch-address registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
        end
    end

    // Next-state logic. A jump always wins over a load.
    // In ISSUE, an accepted instruction is refilled from the word already
    // addressed by pc, which sustains one instruction per cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (jump_en) begin
                    pc_d = jump_addr;
                end else if (word_ok) begin
                    ir_d    = rom_data;
                    ipc_d   = pc_q;
                    pc_d    = pc_inc;
                    state_d = S_ISSUE;
                end else if (HALT_ON_INVALID) begin
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_ISSUE: begin
                if (jump_en) begin
                    // The held word is either taken this cycle (ready=1)
                    // or dropped; either way it is not reissued.
                    pc_d    = jump_addr;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    if (word_ok) begin
                        ir_d  = rom_data;
                        ipc_d = pc_q;
                        pc_d  = pc_inc;
                    end else if (HALT_ON_INVALID) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                // Jumps are ignored here; only start restarts the stage.
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_addr    = pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign instr_pc    = ipc_q;

    // Decoded fields are plain slices of IR, so they hold while the handshake stalls.
    assign opcode  = ir_q[26:24];
    assign op_flag = ir_q[23];
    assign fld_a   = ir_q[22:21];
    assign fld_b   = ir_q[20:19];
    assign fld_dst = ir_q[18:17];
    assign imm     = ir_q[16:1];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit.
// Three instances share one clock:
//   u_main - default parameters
//   u_wrap - RESET_PC = FFFF with a two-word stub ROM
//   u_skip - HALT_ON_INVALID = 0
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ready;

    // main instance signals
    logic        start_m, jump_m, valid_m, flag_m, halted_m;
    logic [15:0] jaddr_m, addr_m, imm_m, ipc_m;
    logic [26:0] data_m;
    logic [2:0]  op_m;
    logic [1:0]  a_m, b_m, dst_m;

    // wrap instance signals
    logic        start_w, valid_w, flag_w, halted_w;
    logic [15:0] addr_w, imm_w, ipc_w;
    logic [26:0] data_w;
    logic [2:0]  op_w;
    logic [1:0]  a_w, b_w, dst_w;

    // skip instance signals
    logic        start_s, valid_s, flag_s, halted_s;
    logic [15:0] addr_s, imm_s, ipc_s;
    logic [26:0] data_s;
    logic [2:0]  op_s;
    logic [1:0]  a_s, b_s, dst_s;

    logic [26:0] prog [0:15];

    localparam logic [26:0] W_FFFF = {3'd3, 1'b0, 2'd1, 2'd1, 2'd1, 16'hAAAA, 1'b1};
    localparam logic [26:0] W_0000 = {3'd4, 1'b1, 2'd2, 2'd2, 2'd2, 16'h5555, 1'b1};

    // Combinational ROM models.
    always_comb data_m = (addr_m < 16'd16) ? prog[addr_m[3:0]] : 27'd0;
    always_comb data_s = (addr_s < 16'd16) ? prog[addr_s[3:0]] : 27'd0;
    always_comb begin
        data_w = 27'd0;
        if (addr_w == 16'hFFFF)      data_w = W_FFFF;
        else if (addr_w == 16'h0000) data_w = W_0000;
    end

    instr_fetch_unit u_main (
        .clk(clk), .rst_n(rst_n), .start(start_m), .rom_addr(addr_m), .rom_data(data_m),
        .instr_valid(valid_m), .instr_ready(ready), .opcode(op_m), .op_flag(flag_m),
        .fld_a(a_m), .fld_b(b_m), .fld_dst(dst_m), .imm(imm_m), .instr_pc(ipc_m),
        .jump_en(jump_m), .jump_addr(jaddr_m), .halted(halted_m)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_w), .rom_addr(addr_w), .rom_data(data_w),
        .instr_valid(valid_w), .instr_ready(ready), .opcode(op_w), .op_flag(flag_w),
        .fld_a(a_w), .fld_b(b_w), .fld_dst(dst_w), .imm(imm_w), .instr_pc(ipc_w),
        .jump_en(1'b0), .jump_addr(16'h0000), .halted(halted_w)
    );

    instr_fetch_unit #(.HALT_ON_INVALID(1'b0)) u_skip (
        .clk(clk), .rst_n(rst_n), .start(start_s), .rom_addr(addr_s), .rom_data(data_s),
        .instr_valid(valid_s), .instr_ready(ready), .opcode(op_s), .op_flag(flag_s),
        .fld_a(a_s), .fld_b(b_s), .fld_dst(dst_s), .imm(imm_s), .instr_pc(ipc_s),
        .jump_en(1'b0), .jump_addr(16'h0000), .halted(halted_s)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] pc;
        logic [26:0] word;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        rdy;
        logic        jmp;
        logic [15:0] jaddr;
        logic        e_valid;
        logic [15:0] e_ipc;
        logic [2:0]  e_op;
        logic        e_halted;
        logic [15:0] e_addr;
    } row_t;
    row_t tbl[21];

    function automatic logic [26:0] mkw(input logic [2:0] op, input logic f, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] d, input logic [15:0] im);
        return {op, f, a, b, d, im, 1'b1};
    endfunction

    function automatic row_t mkrow(input logic r, input logic j, input logic [15:0] ja, input logic v,
                                   input logic [15:0] ipc, input logic [2:0] op, input logic h,
                                   input logic [15:0] ad);
        row_t x;
        x.rdy = r; x.jmp = j; x.jaddr = ja; x.e_valid = v;
        x.e_ipc = ipc; x.e_op = op; x.e_halted = h; x.e_addr = ad;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_t e;
            e.pc   = 16'(i);
            e.word = prog[i];
            sb.push_back(e);
        end
    endtask

    // Called when the main instance shows valid with ready driven high: that word is accepted.
    task automatic accept_m();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got instr_pc %0h expected none", ipc_m);
            return;
        end
        e = sb.pop_front();
        $display("accept pc=%04h op=%0d imm=%04h", ipc_m, op_m, imm_m);
        chk("acc_pc",     32'(ipc_m),  32'(e.pc));
        chk("acc_opcode", 32'(op_m),   32'(e.word[26:24]));
        chk("acc_flag",   32'(flag_m), 32'(e.word[23]));
        chk("acc_a",      32'(a_m),    32'(e.word[22:21]));
        chk("acc_b",      32'(b_m),    32'(e.word[20:19]));
        chk("acc_dst",    32'(dst_m),  32'(e.word[18:17]));
        chk("acc_imm",    32'(imm_m),  32'(e.word[16:1]));
    endtask

    logic [2:0]  cap_op   [0:15];
    logic        cap_flag [0:15];
    logic [1:0]  cap_a    [0:15];
    logic [1:0]  cap_dst  [0:15];
    logic [15:0] cap_imm  [0:15];
    logic [15:0] seq_q[$];
    logic [15:0] imm_q[$];

    initial begin
        int first_v;
        int last_v;
        int nvalid;
        logic any_halt;
        logic [2:0] exp_ops [0:8];

        // Test program: words 0..8 valid, 9 invalid, 10 valid (reached only by u_skip).
        prog[0]  = mkw(3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h000A);
        prog[1]  = mkw(3'd0, 1'b0, 2'd1, 2'd0, 2'd1, 16'h0005);
        prog[2]  = mkw(3'd1, 1'b0, 2'd0, 2'd0, 2'd2, 16'h1234);
        prog[3]  = mkw(3'd2, 1'b0, 2'd2, 2'd1, 2'd3, 16'h0033);
        prog[4]  = mkw(3'd3, 1'b0, 2'd0, 2'd0, 2'd0, 16'h4444);
        prog[5]  = mkw(3'd4, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0055);
        prog[6]  = mkw(3'd5, 1'b0, 2'd0, 2'd0, 2'd0, 16'hBEEF);
        prog[7]  = mkw(3'd6, 1'b0, 2'd0, 2'd3, 2'd0, 16'h0007);
        prog[8]  = mkw(3'd7, 1'b0, 2'd3, 2'd2, 2'd1, 16'hFFFF);
        prog[9]  = 27'd0;
        prog[10] = mkw(3'd5, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0ABC);
        for (int i = 11; i < 16; i++) prog[i] = 27'd0;

        exp_ops = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 16; i++) begin
            cap_op[i] = '0; cap_flag[i] = '0; cap_a[i] = '0; cap_dst[i] = '0; cap_imm[i] = '0;
        end

        rst_n = 1'b0; ready = 1'b0; start_m = 1'b0; start_w = 1'b0; start_s = 1'b0;
        jump_m = 1'b0; jaddr_m = 16'h0000;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_valid",  32'(valid_m),  32'd0);
        chk("rst_halted", 32'(halted_m), 32'd0);
        chk("rst_addr",   32'(addr_m),   32'h0000);
        chk("rst_ipc",    32'(ipc_m),    32'h0000);
        chk("rst_opcode", 32'(op_m),     32'd0);
        chk("rst_flag",   32'(flag_m),   32'd0);
        chk("rst_fields", 32'({a_m, b_m, dst_m}), 32'd0);
        chk("rst_imm",    32'(imm_m),    32'h0000);
        chk("rst_addr_w", 32'(addr_w),   32'hFFFF);
        rst_n = 1'b1;
        tick();

        // ---------------- ready tied high, straight-line run ----------------
        ready = 1'b1;
        push_range(0, 8);
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        first_v = -1; last_v = -1; nvalid = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (valid_m) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                nvalid++;
                cap_op[ipc_m[3:0]]   = op_m;
                cap_flag[ipc_m[3:0]] = flag_m;
                cap_a[ipc_m[3:0]]    = a_m;
                cap_dst[ipc_m[3:0]]  = dst_m;
                cap_imm[ipc_m[3:0]]  = imm_m;
                accept_m();
            end
            tick();
        end
        chk("start_latency", 32'(first_v), 32'd2);
        chk("valid_count",   32'(nvalid),  32'd9);
        chk("last_valid",    32'(last_v),  32'd10);
        chk("halt_after_9",  32'(halted_m), 32'd1);
        chk("halt_pc",       32'(addr_m),  32'h0009);
        chk("sb_drained_1",  32'(sb.size()), 32'd0);
        for (int i = 0; i < 9; i++) chk($sformatf("opcode_w%0d", i), 32'(cap_op[i]), 32'(exp_ops[i]));
        chk("w0_imm",  32'(cap_imm[0]), 32'h000A);
        chk("w0_dst",  32'(cap_dst[0]), 32'd0);
        chk("w1_imm",  32'(cap_imm[1]), 32'h0005);
        chk("w1_a",    32'(cap_a[1]),   32'd1);
        chk("w1_dst",  32'(cap_dst[1]), 32'd1);
        chk("w2_dst",  32'(cap_dst[2]), 32'd2);
        chk("w5_flag", 32'(cap_flag[5]), 32'd1);

        // ---------------- asynchronous reset mid-stream ----------------
        ready = 1'b0;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        tick(); tick();
        chk("pre_rst_valid", 32'(valid_m), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",  32'(valid_m),  32'd0);
        chk("midrst_halted", 32'(halted_m), 32'd0);
        chk("midrst_addr",   32'(addr_m),   32'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            chk("postrst_idle_valid", 32'(valid_m), 32'd0);
            chk("postrst_idle_addr",  32'(addr_m),  32'h0000);
        end

        // ---------------- stall, jump-discard and refill table ----------------
        tbl[0]  = mkrow(1, 0, 16'h0, 0, 16'h0, 3'd0, 0, 16'h0000);
        tbl[1]  = mkrow(1, 0, 16'h0, 1, 16'h0, 3'd0, 0, 16'h0001);
        tbl[2]  = mkrow(1, 0, 16'h0, 1, 16'h1, 3'd0, 0, 16'h0002);
        tbl[3]  = mkrow(1, 0, 16'h0, 1, 16'h2, 3'd1, 0, 16'h0003);
        tbl[4]  = mkrow(0, 0, 16'h0, 1, 16'h3, 3'd2, 0, 16'h0004);
        tbl[5]  = mkrow(0, 0, 16'h0, 1, 16'h3, 3'd2, 0, 16'h0004);
        tbl[6]  = mkrow(0, 0, 16'h0, 1, 16'h3, 3'd2, 0, 16'h0004);
        tbl[7]  = mkrow(1, 0, 16'h0, 1, 16'h3, 3'd2, 0, 16'h0004);
        tbl[8]  = mkrow(0, 1, 16'h1, 1, 16'h4, 3'd3, 0, 16'h0005);
        tbl[9]  = mkrow(1, 0, 16'h0, 0, 16'h0, 3'd0, 0, 16'h0001);
        tbl[10] = mkrow(1, 0, 16'h0, 1, 16'h1, 3'd0, 0, 16'h0002);
        tbl[11] = mkrow(1, 0, 16'h0, 1, 16'h2, 3'd1, 0, 16'h0003);
        tbl[12] = mkrow(1, 0, 16'h0, 1, 16'h3, 3'd2, 0, 16'h0004);
        tbl[13] = mkrow(1, 0, 16'h0, 1, 16'h4, 3'd3, 0, 16'h0005);
        tbl[14] = mkrow(1, 0, 16'h0, 1, 16'h5, 3'd4, 0, 16'h0006);
        tbl[15] = mkrow(1, 0, 16'h0, 1, 16'h6, 3'd5, 0, 16'h0007);
        tbl[16] = mkrow(1, 0, 16'h0, 1, 16'h7, 3'd6, 0, 16'h0008);
        tbl[17] = mkrow(1, 0, 16'h0, 1, 16'h8, 3'd7, 0, 16'h0009);
        tbl[18] = mkrow(1, 0, 16'h0, 0, 16'h0, 3'd0, 1, 16'h0009);
        tbl[19] = mkrow(0, 1, 16'h2, 0, 16'h0, 3'd0, 1, 16'h0009);
        tbl[20] = mkrow(0, 0, 16'h0, 0, 16'h0, 3'd0, 1, 16'h0009);

        push_range(0, 3);
        push_range(1, 8);
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        for (int r = 0; r < 21; r++) begin
            chk($sformatf("row%0d_valid", r),  32'(valid_m),  32'(tbl[r].e_valid));
            chk($sformatf("row%0d_halted", r), 32'(halted_m), 32'(tbl[r].e_halted));
            chk($sformatf("row%0d_addr", r),   32'(addr_m),   32'(tbl[r].e_addr));
            if (tbl[r].e_valid) begin
                chk($sformatf("row%0d_ipc", r), 32'(ipc_m), 32'(tbl[r].e_ipc));
                chk($sformatf("row%0d_op", r),  32'(op_m),  32'(tbl[r].e_op));
            end
            ready   = tbl[r].rdy;
            jump_m  = tbl[r].jmp;
            jaddr_m = tbl[r].jaddr;
            if (valid_m && ready) accept_m();
            tick();
        end
        jump_m = 1'b0;
        chk("sb_drained_2", 32'(sb.size()), 32'd0);

        // ---------------- PC wrap from FFFF ----------------
        ready = 1'b1;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        any_halt = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (valid_w) begin
                $display("wrap pc=%04h imm=%04h", ipc_w, imm_w);
                seq_q.push_back(ipc_w);
                imm_q.push_back(imm_w);
                if (halted_w) any_halt = 1'b1;
            end
            tick();
        end
        chk("wrap_count", 32'(seq_q.size()), 32'd2);
        if (seq_q.size() == 2) begin
            chk("wrap_pc0",  32'(seq_q[0]), 32'hFFFF);
            chk("wrap_pc1",  32'(seq_q[1]), 32'h0000);
            chk("wrap_imm0", 32'(imm_q[0]), 32'hAAAA);
            chk("wrap_imm1", 32'(imm_q[1]), 32'h5555);
        end
        chk("wrap_no_halt_while_valid", 32'(any_halt), 32'd0);
        chk("wrap_end_addr", 32'(addr_w), 32'h0001);

        // ---------------- skip invalid word ----------------
        seq_q.delete();
        imm_q.delete();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        any_halt = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (halted_s) any_halt = 1'b1;
            if (valid_s) begin
                $display("skip pc=%04h imm=%04h", ipc_s, imm_s);
                seq_q.push_back(ipc_s);
                imm_q.push_back(imm_s);
            end
            tick();
        end
        chk("skip_count", 32'(seq_q.size()), 32'd10);
        if (seq_q.size() == 10) begin
            chk("skip_pc8",   32'(seq_q[8]), 32'h0008);
            chk("skip_pc9",   32'(seq_q[9]), 32'h000A);
            chk("skip_imm10", 32'(imm_q[9]), 32'h0ABC);
        end
        chk("skip_never_halted", 32'(any_halt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
